// File: rtl/cpu7_ifu_imem_resp_pkg.sv
// Shared types and constants for the IFU instruction-memory responder.
//   IMEM_LINE_W   : SRAM line width in bits (4 instruction words)
//   EXCCODE_ADEF  : exception code reported for misaligned fetches
//   resp_pipe_t   : per-stage response pipeline payload
package cpu7_ifu_imem_resp_pkg;

  localparam int unsigned IMEM_LINE_W = 128;
  localparam int unsigned WORD_W      = 32;
  localparam logic [5:0]  EXCCODE_ADEF = 6'h08;
  localparam logic [7:0]  LFSR_SEED    = 8'hA5;

  typedef struct packed {
    logic       v;
    logic       ex;
    logic       uc;
    logic [1:0] sh;
  } resp_pipe_t;

  // Fibonacci step of x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Valid words following slot 0 in the rotated line.
  function automatic logic [1:0] extra_words(input logic [1:0] sh);
    return 2'd3 - sh;
  endfunction

endpackage

// File: rtl/cpu7_imem_rot128.sv
// Combinational word rotate of one SRAM line so the requested word lands in
// slot 0; vacated upper slots are zero filled.
//   line  : raw 128-bit SRAM line
//   sh    : word offset of the requested instruction (addr[3:2])
//   rot_c : shifted line, [31:0] = word sh of line
module cpu7_imem_rot128
  import cpu7_ifu_imem_resp_pkg::*;
(
  input  logic [IMEM_LINE_W-1:0] line,
  input  logic [1:0]             sh,
  output logic [IMEM_LINE_W-1:0] rot_c
);

  always_comb begin
    rot_c = '0;
    case (sh)
      2'd0: rot_c = line;
      2'd1: rot_c = {32'd0, line[127:32]};
      2'd2: rot_c = {64'd0, line[127:64]};
      2'd3: rot_c = {96'd0, line[127:96]};
      default: rot_c = '0;
    endcase
  end

endmodule

// File: rtl/cpu7_ifu_imem_resp.sv
// Responder end of the IFU inst_* fetch interface in front of a synchronous
// 128-bit instruction SRAM. Each accepted fetch reads one line, and RAM_LAT
// cycles later returns it rotated so slot 0 holds the requested word.
// Misaligned fetches skip the SRAM and return an ADEF exception.
// inst_cancel drops every response accepted before the cancel cycle.
//
// Optional build macro CPU7_IMEM_RESP_STALL_EN: an 8-bit LFSR refuses about
// a quarter of requests to exercise the fetch unit's retry path.
//
// Ports:
//   clock, reset        : core clock, synchronous active-high reset
//   inst_req/inst_addr  : fetch request and byte address
//   inst_cancel         : kill all earlier accepted requests
//   inst_addr_ok        : request accepted this cycle
//   inst_valid ..       : response (rdata, count, ex, exccode, uncache)
//   ram_en/ram_addr     : SRAM read port
//   ram_rdata           : SRAM data, RAM_LAT cycles after ram_en
module cpu7_ifu_imem_resp
  import cpu7_ifu_imem_resp_pkg::*;
#(
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned LINE_AW = 12,
  parameter logic [2:0]  UC_SEG  = 3'b101
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inst_req,
  input  logic [31:0]            inst_addr,
  input  logic                   inst_cancel,
  output logic                   inst_addr_ok,
  output logic                   inst_valid,
  output logic [IMEM_LINE_W-1:0] inst_rdata,
  output logic [1:0]             inst_count,
  output logic                   inst_ex,
  output logic [5:0]             inst_exccode,
  output logic                   inst_uncache,
  output logic                   ram_en,
  output logic [LINE_AW-1:0]     ram_addr,
  input  logic [IMEM_LINE_W-1:0] ram_rdata
);

  logic                   accept;
  logic                   aligned;
  logic                   head_ok;
  logic [IMEM_LINE_W-1:0] rot_line;
  resp_pipe_t             pipe [RAM_LAT];
  resp_pipe_t             head;

  // Middle address bits above the SRAM window are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^inst_addr;

`ifdef CPU7_IMEM_RESP_STALL_EN
  logic [7:0] lfsr;

  // Free-running refusal pattern, restarted from the seed on reset.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign inst_addr_ok = ~reset & (lfsr[1:0] != 2'd0);
`else
  assign inst_addr_ok = ~reset;
`endif

  assign aligned  = (inst_addr[1:0] == 2'd0);
  assign accept   = inst_req & inst_addr_ok;
  assign ram_en   = accept & aligned;
  assign ram_addr = inst_addr[LINE_AW+3:4];

  // Response pipe. Cancel clears entries already in flight; the request
  // presented alongside the cancel still enters stage 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < RAM_LAT; i++) pipe[i].v <= 1'b0;
    end else begin
      pipe[0].v <= accept;
      for (int unsigned i = 1; i < RAM_LAT; i++) pipe[i].v <= pipe[i-1].v & ~inst_cancel;
    end
    pipe[0].ex <= ~aligned;
    pipe[0].uc <= (inst_addr[31:29] == UC_SEG);
    pipe[0].sh <= inst_addr[3:2];
    for (int unsigned i = 1; i < RAM_LAT; i++) begin
      pipe[i].ex <= pipe[i-1].ex;
      pipe[i].uc <= pipe[i-1].uc;
      pipe[i].sh <= pipe[i-1].sh;
    end
  end

  assign head = pipe[RAM_LAT-1];

  cpu7_imem_rot128 u_rot (
    .line  (ram_rdata),
    .sh    (head.sh),
    .rot_c (rot_line)
  );

  // Cancel and reset suppress the response in their own cycle.
  assign inst_valid   = head.v & ~inst_cancel & ~reset;
  assign head_ok      = inst_valid & ~head.ex;
  assign inst_ex      = inst_valid & head.ex;
  assign inst_exccode = inst_ex ? EXCCODE_ADEF : 6'd0;
  assign inst_uncache = inst_valid & head.uc;
  assign inst_count   = head_ok ? extra_words(head.sh) : 2'd0;
  assign inst_rdata   = head_ok ? rot_line : '0;

endmodule

// File: tb/tb_cpu7_ifu_imem_resp.sv
// Scoreboard bench for cpu7_ifu_imem_resp: two instances (RAM_LAT 1 and 3)
// share stimulus; each has its own SRAM model and expectation queue.
module tb_cpu7_ifu_imem_resp;

  localparam int unsigned ND = 2;

  typedef struct {
    int          due;
    logic        ex;
    logic        uc;
    logic [1:0]  sh;
    logic [11:0] line;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic inst_req = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic inst_cancel = 1'b0;

  logic         addr_ok  [ND];
  logic         valid    [ND];
  logic [127:0] rdata    [ND];
  logic [1:0]   count    [ND];
  logic         ex       [ND];
  logic [5:0]   exccode  [ND];
  logic         uncache  [ND];
  logic         ram_en   [ND];
  logic [11:0]  ram_addr [ND];
  logic [127:0] ram_rdata[ND];

  logic [11:0] ap0;
  logic [11:0] ap1 [3];

  exp_t sbq [ND][$];
  int   lat_of [ND] = '{1, 3};
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   cur_dut = 0;
  logic [7:0] lfsr_m = 8'hA5;
  int   refused = 0;
  int   offered = 0;

  always #5 clock = ~clock;

  cpu7_ifu_imem_resp #(.RAM_LAT(1), .LINE_AW(12), .UC_SEG(3'b101)) u_dut1 (
    .clock(clock), .reset(reset), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_cancel(inst_cancel), .inst_addr_ok(addr_ok[0]), .inst_valid(valid[0]),
    .inst_rdata(rdata[0]), .inst_count(count[0]), .inst_ex(ex[0]),
    .inst_exccode(exccode[0]), .inst_uncache(uncache[0]), .ram_en(ram_en[0]),
    .ram_addr(ram_addr[0]), .ram_rdata(ram_rdata[0])
  );

  cpu7_ifu_imem_resp #(.RAM_LAT(3), .LINE_AW(12), .UC_SEG(3'b101)) u_dut3 (
    .clock(clock), .reset(reset), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_cancel(inst_cancel), .inst_addr_ok(addr_ok[1]), .inst_valid(valid[1]),
    .inst_rdata(rdata[1]), .inst_count(count[1]), .inst_ex(ex[1]),
    .inst_exccode(exccode[1]), .inst_uncache(uncache[1]), .ram_en(ram_en[1]),
    .ram_addr(ram_addr[1]), .ram_rdata(ram_rdata[1])
  );

  // Distinct contents per line and word: word k of line L = C{k}000LLL.
  function automatic logic [127:0] line_data(input logic [11:0] l);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = {4'hC, 4'(k), 12'h000, l};
    return d;
  endfunction

  // SRAM models: data presented RAM_LAT cycles after the address.
  always_ff @(posedge clock) begin
    ap0    <= ram_addr[0];
    ap1[0] <= ram_addr[1];
    ap1[1] <= ap1[0];
    ap1[2] <= ap1[1];
  end
  assign ram_rdata[0] = line_data(ap0);
  assign ram_rdata[1] = line_data(ap1[2]);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d lat=%0d got=%h exp=%h", tag, cyc, lat_of[cur_dut], got, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic req, input logic [31:0] addr,
                           input logic cancel, input logic rst);
    logic ok_exp;
    logic acc;
    logic al;
    exp_t e;
    cur_dut = d;
`ifdef CPU7_IMEM_RESP_STALL_EN
    ok_exp = ~rst & (lfsr_m[1:0] != 2'd0);
`else
    ok_exp = ~rst;
`endif
    chk("addr_ok", 128'(addr_ok[d]), 128'(ok_exp));
    acc = req & ok_exp;
    al  = (addr[1:0] == 2'd0);
    chk("ram_en", 128'(ram_en[d]), 128'(acc & al));
    if (acc && al) chk("ram_addr", 128'(ram_addr[d]), 128'(addr[15:4]));

    if (rst || cancel) begin
      chk("valid_kill", 128'(valid[d]), 128'(0));
      sbq[d].delete();
    end else if (sbq[d].size() > 0 && sbq[d][0].due == cyc) begin
      e = sbq[d].pop_front();
      chk("valid", 128'(valid[d]), 128'(1));
      chk("ex", 128'(ex[d]), 128'(e.ex));
      chk("exccode", 128'(exccode[d]), e.ex ? 128'(6'h08) : 128'(0));
      chk("uncache", 128'(uncache[d]), 128'(e.uc));
      chk("count", 128'(count[d]), e.ex ? 128'(0) : 128'(2'd3 - e.sh));
      chk("rdata", rdata[d], e.ex ? 128'(0) : (line_data(e.line) >> (32 * int'(e.sh))));
    end else begin
      chk("valid_idle", 128'(valid[d]), 128'(0));
    end
    if (!valid[d])
      chk("resp_zero", {rdata[d][119:0], count[d], ex[d], exccode[d], uncache[d]}, 128'(0));

    if (acc) begin
      e.due  = cyc + lat_of[d];
      e.ex   = ~al;
      e.uc   = (addr[31:29] == 3'b101);
      e.sh   = addr[3:2];
      e.line = addr[15:4];
      sbq[d].push_back(e);
    end
  endtask

  // One clock cycle: drive after the edge, check on the falling edge.
  task automatic step(input logic req, input logic [31:0] addr,
                      input logic cancel, input logic rst);
    inst_req = req; inst_addr = addr; inst_cancel = cancel; reset = rst;
    @(negedge clock);
    if (req && !rst) begin
      offered++;
      if (!addr_ok[0]) refused++;
    end
    for (int d = 0; d < ND; d++) check_dut(d, req, addr, cancel, rst);
    @(posedge clock);
    #1;
    lfsr_m = rst ? 8'hA5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b1);

    step(1'b1, 32'h1C00_0008, 1'b0, 1'b0);
    idle(4);

    step(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0004, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0008, 1'b0, 1'b0);
    step(1'b1, 32'h0000_000C, 1'b0, 1'b0);
    idle(4);

    step(1'b1, 32'h1C00_0002, 1'b0, 1'b0);
    idle(4);

    // A, B, then cancel with redirect C.
    step(1'b1, 32'h1C00_0100, 1'b0, 1'b0);
    step(1'b1, 32'h1C00_0114, 1'b0, 1'b0);
    step(1'b1, 32'h1C00_0228, 1'b1, 1'b0);
    idle(5);

    // Back-to-back cancels, each with its own redirect.
    step(1'b1, 32'h0000_0330, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0344, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0358, 1'b1, 1'b0);
    step(1'b1, 32'h0000_036C, 1'b1, 1'b0);
    idle(5);

    // Cancel and reset together, then uncached fetch and reset mid-flight.
    step(1'b1, 32'h0000_0400, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0410, 1'b1, 1'b1);
    step(1'b1, 32'hA000_0010, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 32'hA000_0020, 1'b0, 1'b0);
    step(1'b1, 32'h1C00_0034, 1'b0, 1'b0);
    step(1'b1, 32'h1C00_0040, 1'b0, 1'b1);
    step(1'b1, 32'h1C00_0044, 1'b0, 1'b1);
    idle(5);

    // Random traffic with occasional cancel/reset.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      step(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 63) == 0));
    end
    idle(5);

`ifdef CPU7_IMEM_RESP_STALL_EN
    offered = 0;
    refused = 0;
    for (int i = 0; i < 1000; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
    idle(5);
    chk("refuse_rate", 128'((refused * 100 >= offered * 20) && (refused * 100 <= offered * 30)), 128'(1));
`endif

    for (int d = 0; d < ND; d++) begin
      cur_dut = d;
      chk("sb_drained", 128'(sbq[d].size()), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
